// File: rtl/mem_resp.sv
// Single-port word memory slave with active-low strobe/ready handshake and out-of-range flag.
// Optional wait-state insertion is enabled by defining MEM_RESP_WAIT_EN.
module mem_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
        $error("mem_resp: WAIT_CYC must be in 0..15");
    end

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rdy_n_q, rdy_n_d;
    logic        err_q, err_d;
    logic [31:0] rd_data_q;

`ifdef MEM_RESP_WAIT_EN
    localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    logic [3:0]  cnt_q, cnt_d;
`endif

    logic [31:0]       mem [2**ADDR_W];
    logic              accept;
    logic              in_range_q, in_range_d;
    logic              mem_we, rd_en;
    logic [ADDR_W-1:0] wr_idx, rd_idx;

    assign accept = (state_q == S_IDLE) && !as_;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!as_) begin
`ifdef MEM_RESP_WAIT_EN
                    state_d = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
`else
                    state_d = S_ACK;
`endif
                end
            end
            S_WAIT: begin
`ifdef MEM_RESP_WAIT_EN
                if (as_)              state_d = S_IDLE;
                else if (cnt_q == '0) state_d = S_ACK;
`else
                state_d = S_IDLE;
`endif
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch and wait counter
    always_comb begin
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            rw_d    = rw;
            addr_d  = addr;
            wdata_d = wr_data;
        end
`ifdef MEM_RESP_WAIT_EN
        cnt_d = cnt_q;
        if (accept)
            cnt_d = CNT_LOAD;
        else if (state_q == S_WAIT && cnt_q != '0)
            cnt_d = cnt_q - 4'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_RESP_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_RESP_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs are registered off the next state so they line up with the ACK cycle
    always_comb begin
        in_range_d = (addr_d >> ADDR_W) == '0;
        in_range_q = (addr_q >> ADDR_W) == '0;
        rdy_n_d    = (state_d != S_ACK);
        err_d      = (state_d == S_ACK) && !in_range_d;
        rd_en      = (state_d == S_ACK) && rw_d && in_range_d;
        rd_idx     = addr_d[ADDR_W-1:0];
        wr_idx     = addr_q[ADDR_W-1:0];
        mem_we     = (state_q == S_ACK) && !rw_q && in_range_q && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_n_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            rdy_n_q <= rdy_n_d;
            err_q   <= err_d;
        end
    end

    // RAM: write at the end of ACK, registered read into the ACK cycle; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset)      rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem[rd_idx];
        else            rd_data_q <= '0;
    end

    assign rd_data = rd_data_q;
    assign rdy_    = rdy_n_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter: ADDR_W, 10, number of word-index bits decoded (depth = 2^ADDR_W words).
REQ-002 Parameter: WAIT_CYC, 2, wait cycles inserted before ready (range 0..15; used only when MEM_RESP_WAIT_EN is defined).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 as_  input  1  address strobe, active-low, held low by requester until rdy_ seen.
REQ-007 rw  input  1  READ=1, WRITE=0 (codebase encoding).
REQ-008 addr  input  30  word address (WordAddrBus).
REQ-009 wr_data  input  32  write data (WordDataBus).
REQ-010 rd_data  output  32  read data, registered, valid only while rdy_ is low on a read.
REQ-011 rdy_  output  1  ready, active-low, registered, one-cycle pulse per transaction.
REQ-012 err  output  1  out-of-range flag, registered, coincides with rdy_ low.
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, ACK, encoded in 2 bits.
REQ-015 In IDLE with as_ low at a rising edge, the block SHALL latch addr, rw and wr_data, then go to WAIT with the counter loaded to WAIT_CYC-1, or go directly to ACK if WAIT_CYC is 0.
REQ-016 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL go to ACK after the edge where the counter reads 0.
REQ-017 Latency: request accepted at edge N SHALL produce rdy_ low during cycle N+1+WAIT_CYC, for exactly one cycle.
REQ-018 In ACK: rdy_=0; a read SHALL drive rd_data = mem[addr_q[ADDR_W-1:0]]; a write SHALL update mem at the ACK edge; rd_data SHALL be 0 on writes.
REQ-019 After ACK the FSM SHALL return to IDLE; the next request SHALL be accepted no earlier than the edge following ACK, giving one idle turnaround cycle.
REQ-020 Out of range (addr_q[29:ADDR_W] != 0): no memory write, rd_data=0, and err=1 in the ACK cycle.
REQ-021 Abort: if as_ goes high while in WAIT, the FSM SHALL return to IDLE on that edge with no write, no rdy_ and no err.
REQ-022 as_ SHALL be ignored in ACK, and input changes after latching SHALL NOT affect the transaction.
REQ-023 Outside ACK: rdy_=1, err=0, rd_data=0.
REQ-024 Memory array SHALL be 2^ADDR_W x 32, single-port, and inferable as synchronous RAM.

Reset
REQ-025 On reset high at a clock edge, the block SHALL set FSM=IDLE, counter=0, rdy_=1, rd_data=0, err=0, busy=0, and clear the latched request.
REQ-026 Reset during WAIT or ACK SHALL abandon the transaction, with no memory write at that edge.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_RESP_WAIT_EN: when defined, WAIT state and counter exist and WAIT_CYC applies.
REQ-029 Without MEM_RESP_WAIT_EN: no WAIT state or counter, IDLE goes directly to ACK, fixed latency rdy_ at cycle N+1, and WAIT_CYC is ignored.

Verification
REQ-030 With WAIT_CYC=2, write addr=0x5, data=0xDEADBEEF, then read addr=0x5: expect rdy_ low at N+3 for each, read rd_data=0xDEADBEEF, err=0.
REQ-031 Read addr=0x400 with ADDR_W=10: expect rdy_ low, err=1, rd_data=0; a subsequent read of addr=0x0 shows data unchanged.
REQ-032 Write addr=0x7, then raise as_ at cycle N+1 (in WAIT): expect no rdy_, busy low at N+2, and mem[7] keeps its old value.
REQ-033 Assert reset during ACK of a write to addr=0x9: expect rdy_=1 next cycle, mem[9] unchanged, FSM in IDLE.
REQ-034 Hold as_ low continuously over two reads (0x1, 0x2): expect two single-cycle rdy_ pulses separated by at least one idle cycle plus WAIT_CYC wait cycles.
REQ-035 Build without MEM_RESP_WAIT_EN, read addr=0x3: expect rdy_ low at cycle N+1 regardless of WAIT_CYC=5.
